// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It oversamples the line at CLKS_PER_BIT clocks
// per bit, samples every bit at mid-bit and recovers each byte LSB-first.
// A received byte is held on a valid/ack handshake. frame_err pulses for one
// cycle on a bad stop bit. overrun is sticky and reports a dropped byte.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - serial line, idle high, asynchronous to clk
//   data       - received byte, valid while data_valid=1
//   data_valid - level, held until data_ack
//   data_ack   - consumer accepts the byte (ignored while data_valid=0)
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   overrun    - sticky, set when a good frame completes while data_valid=1
//   state      - FSM state for debug visibility
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic             rx_meta;
    logic             rx_s;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q,   shreg_d;

    logic [7:0]       data_d;
    logic             data_valid_d;
    logic             frame_err_d;
    logic             overrun_d;
    logic             good_frame_c;

    // Two-flop synchronizer; the FSM only ever looks at rx_s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            frame_err  <= frame_err_d;
            overrun    <= overrun_d;
        end
    end

    // Next-state, bit timing and handshake logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        data_d       = data;
        data_valid_d = data_valid;
        frame_err_d  = 1'b0;
        overrun_d    = overrun;
        good_frame_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                // Re-check the start bit at its mid-point to reject glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        good_frame_c = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                // A held-low or break line must return high before re-arming.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Ack retires the held byte and clears overrun.
        if (data_valid && data_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        // A completed frame replaces the byte only if the slot is free or
        // being freed on this same edge; otherwise it is dropped.
        if (good_frame_c) begin
            if (!data_valid || data_ack) begin
                data_d       = shreg_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The stimulus side serialises
// bytes and pushes the bytes that should be delivered; a monitor pops and
// compares each time the DUT presents a new byte.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_start_cyc = 0;
    int last_valid_cyc = 0;
    int fe_count = 0;

    logic [7:0] exp_q[$];
    logic       mdl_valid = 1'b0;
    logic       mdl_overrun = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a new byte is presented when data_valid rises, or when it
    // stays high across an edge on which the previous byte was acked.
    logic prev_valid = 1'b0;
    logic prev_ack   = 1'b0;
    logic prev_fe    = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            prev_fe    = 1'b0;
        end else begin
            if (data_valid && (!prev_valid || prev_ack)) begin
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                fe_count++;
                if (prev_fe) chk("frame_err_width", 32'd2, 32'd1);
            end
            prev_valid = data_valid;
            prev_ack   = data_ack;
            prev_fe    = frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame is delivered if the slot is empty or
    // acked on the completing edge; otherwise it is lost and overrun sets.
    task automatic model_frame(input logic [7:0] b, input logic ack_edge);
        if (!mdl_valid || ack_edge) begin
            exp_q.push_back(b);
            mdl_valid   = 1'b1;
            mdl_overrun = 1'b0;
        end else begin
            mdl_overrun = 1'b1;
        end
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        if (mdl_valid) begin
            mdl_valid   = 1'b0;
            mdl_overrun = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_start_cyc = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 400; i++) begin
            if (data_valid) break;
            tick(1);
        end
        chk(name, 32'(data_valid), 32'd1);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"},   32'(data_valid), 32'(mdl_valid));
        chk({tag, "_overrun"}, 32'(overrun),    32'(mdl_overrun));
        chk({tag, "_ferr"},    32'(frame_err),  32'd0);
    endtask

    initial begin
        int lat;
        int seen_start;
        logic [7:0] b;

        reset    = 1'b0;
        rx       = 1'b1;
        data_ack = 1'b0;
        tick(3);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        reset = 1'b1;
        tick(5);

        // Basic byte, ack three clocks after valid.
        model_frame(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        wait_valid("a5_valid_timeout");
        lat = last_valid_cyc - frame_start_cyc;
        chk("a5_latency_in_range", 32'((lat >= 153) && (lat <= 155)), 32'd1);
        chk("a5_data", 32'(data), 32'hA5);
        tick(3);
        chk("a5_held", 32'(data_valid), 32'd1);
        do_ack();
        check_outputs("a5_after_ack");
        chk("a5_state", 32'(state), 32'd0);

        // Short low glitch while idle.
        seen_start = 0;
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) rx = 1'b1;
            tick(1);
            if (state == 3'd1) seen_start = 1;
        end
        chk("glitch_saw_start", 32'(seen_start), 32'd1);
        chk("glitch_state", 32'(state), 32'd0);
        check_outputs("glitch");

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0);
        chk("ferr_wait_state", 32'(state), 32'd4);
        tick(40);
        chk("ferr_still_wait", 32'(state), 32'd4);
        rx = 1'b1;
        tick(4);
        chk("ferr_back_idle", 32'(state), 32'd0);
        chk("ferr_count", 32'(fe_count), 32'd1);
        check_outputs("ferr");

        // Back-to-back with no ack: second byte lost, overrun set.
        model_frame(8'h11, 1'b0);
        send_frame(8'h11, 1'b1);
        model_frame(8'h22, 1'b0);
        send_frame(8'h22, 1'b1);
        chk("ovr_data", 32'(data), 32'h11);
        check_outputs("ovr");
        do_ack();
        check_outputs("ovr_acked");
        model_frame(8'h33, 1'b0);
        send_frame(8'h33, 1'b1);
        chk("ovr_third", 32'(data), 32'h33);
        check_outputs("ovr_third");
        do_ack();

        // Ack exactly on the edge the second frame completes.
        model_frame(8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        model_frame(8'hFF, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(154);
                data_ack = 1'b1;
                tick(1);
                data_ack = 1'b0;
            end
        join
        chk("edge_ack_data", 32'(data), 32'hFF);
        check_outputs("edge_ack");
        do_ack();

        // Reset in the middle of the data bits of 0x0F.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB + 10);
        reset = 1'b0;
        mdl_valid   = 1'b0;
        mdl_overrun = 1'b0;
        tick(2);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        check_outputs("midrst");
        tick(5);
        reset = 1'b1;
        tick(20);
        chk("midrst_idle", 32'(state), 32'd0);
        chk("midrst_no_valid", 32'(data_valid), 32'd0);
        model_frame(8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_valid("r81_valid_timeout");
        chk("r81_data", 32'(data), 32'h81);
        do_ack();

        // Randomized bytes with random ack delay and idle gaps.
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom_range(255, 0));
            model_frame(b, 1'b0);
            send_frame(b, 1'b1);
            wait_valid("rand_valid_timeout");
            tick(int'($urandom_range(8, 1)));
            do_ack();
            check_outputs("rand");
            tick(int'($urandom_range(30, 1)));
        end

        tick(5);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_ferr_count", 32'(fe_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the downstream partner of the team's UART transmitter.
- Consumes the serial line the transmitter drives and recovers bytes LSB-first.
- Oversamples the line at CLKS_PER_BIT clocks per bit and samples each bit at mid-bit.
- Presents each byte on a valid/ack handshake, with framing-error and overrun flags.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
HALF_BIT, CLKS_PER_BIT/2, derived local; start-bit mid-point count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
rx  input  1  serial line, idle high, asynchronous to clk
data  output  8  received byte, valid while data_valid=1
data_valid  output  1  level; byte held until acknowledged
data_ack  input  1  consumer accepts byte; sampled only while data_valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a good frame completed while data_valid=1
state  output  3  FSM state, for debug/visibility

Behaviour:
- Reset (reset=0, async):
  - rx synchronizer flops = 1, state=IDLE(0), counters=0, shift register=0.
  - data=0, data_valid=0, frame_err=0, overrun=0.
  - Reset mid-frame discards the partial byte; after release the receiver waits in IDLE for a new falling edge.
- Input sync: two flops; rx_s = second flop. The FSM uses only rx_s.
- FSM encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
  - IDLE: rx_s=0 -> START, bit counter cnt=0.
  - START: cnt increments each clk. At cnt==HALF_BIT-1, sample rx_s:
    - 0 -> DATA, cnt=0, bit_idx=0.
    - 1 -> IDLE (glitch rejected, no output, no flag).
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first (shreg <= {rx_s, shreg[7:1]}), cnt=0, bit_idx+1.
    - The sample with bit_idx==7 -> STOP.
    - Otherwise cnt increments.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> good frame, IDLE.
    - 0 -> frame_err=1 for exactly one cycle, data/data_valid unchanged, WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE. This prevents a held-low or break line from retriggering.
- Good-frame delivery, on the STOP sample edge:
  - data_valid=0, or data_ack=1 in the same cycle: data<=shreg, data_valid=1.
  - data_valid=1 and data_ack=0: byte discarded, overrun=1, data unchanged.
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid next edge, unless a good frame completes that same edge (then data_valid stays 1 with the new byte).
  - overrun clears on any edge with data_ack=1 and data_valid=1.
  - data_ack while data_valid=0 is ignored.
- Latency: data_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT clks (±1) after rx falls for the start bit.
- Back-to-back frames (stop bit followed immediately by the next start bit) are received without loss, since IDLE reacts in one cycle.
- cnt width: clog2(CLKS_PER_BIT). bit_idx: 3 bits, wraps only via the STOP transition.

Test Plan:
- Reset then send 0xA5 at CLKS_PER_BIT=16, ack 3 clks after valid -> data=0xA5, data_valid high until the ack edge, frame_err=0, overrun=0, state returns to 0.
- Low glitch on rx of 4 clks while IDLE -> state goes 1 then 0, data_valid never asserts, no flags.
- Send 0x3C with stop bit forced low, then rx held low 40 clks, then high -> one frame_err pulse, state=4 for the low period, then 0; data_valid stays 0.
- Send 0x11 then 0x22 back-to-back with no ack -> data=0x11 held, overrun=1. Ack -> overrun=0, data_valid=0. Third byte 0x33 -> data=0x33.
- Send 0x55 then 0xFF back-to-back with ack asserted on the exact edge 0xFF completes -> data=0xFF, data_valid stays 1, overrun=0.
- Assert reset=0 mid-DATA of 0x0F, release, send 0x81 -> partial byte lost, outputs zero during reset, data=0x81 received correctly.
